// File: rtl/servo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module : servo_write_arbiter
// Shares one PCA9685 register-write engine between N_REQ requesters: runs the
// chip init sequence after reset, then grants queued writes round-robin.
// Rev    : 1.0
// ============================================================================
module servo_write_arbiter #(
  parameter int         N_REQ       = 4,
  parameter logic [7:0] PRESCALE    = 8'h79,
  parameter bit         INIT_EN     = 1'b1,
  parameter int         TIMEOUT_CYC = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [8*N_REQ-1:0]       i_addr,
  input  logic [8*N_REQ-1:0]       i_data,
  output logic [N_REQ-1:0]         o_ack,
  output logic                     o_err,
  output logic [$clog2(N_REQ)-1:0] o_grant_id,
  output logic                     o_busy,
  output logic                     o_init_done,
  output logic                     o_start,
  output logic [7:0]               o_reg_addr,
  output logic [7:0]               o_data,
  input  logic                     i_complete
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [GW-1:0] LAST_ID = GW'(N_REQ - 1);

  typedef enum logic [2:0] {
    INIT_SLEEP = 3'd0,
    INIT_PRESC = 3'd1,
    INIT_RUN   = 3'd2,
    IDLE       = 3'd3,
    ISSUE      = 3'd4,
    RELEASE    = 3'd5
  } state_t;

  localparam state_t RESET_STATE = INIT_EN ? INIT_SLEEP : IDLE;

  state_t            state_q, state_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [1:0]        step_q, step_d;
  logic              abort_q, abort_d;
  logic              init_done_q, init_done_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              start_q;
  logic              busy_q;

  logic              arb_found;
  logic [GW-1:0]     arb_id;
  logic [GW-1:0]     cand;
  logic              timeout_hit;

  // Round-robin scan starting one past the last served requester.
  always_comb begin
    arb_found = 1'b0;
    arb_id    = grant_q;
    cand      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = GW'((int'(grant_q) + i) % N_REQ);
      if (!arb_found && i_req[cand]) begin
        arb_found = 1'b1;
        arb_id    = cand;
      end
    end
  end

  assign timeout_hit = (TIMEOUT_CYC > 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    grant_d     = grant_q;
    step_d      = step_q;
    abort_d     = abort_q;
    init_done_d = init_done_q;
    ack_d       = '0;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
    case (state_q)
      INIT_SLEEP: begin
        addr_d  = 8'h00;
        data_d  = 8'h10;
        step_d  = 2'd0;
        abort_d = 1'b0;
        cnt_d   = '0;
        state_d = ISSUE;
      end
      INIT_PRESC: begin
        addr_d  = 8'hFE;
        data_d  = PRESCALE;
        step_d  = 2'd1;
        cnt_d   = '0;
        state_d = ISSUE;
      end
      INIT_RUN: begin
        addr_d  = 8'h00;
        data_d  = 8'h00;
        step_d  = 2'd2;
        cnt_d   = '0;
        state_d = ISSUE;
      end
      IDLE: begin
        if (init_done_q && arb_found) begin
          grant_d = arb_id;
          addr_d  = i_addr[{arb_id, 3'b000} +: 8];
          data_d  = i_data[{arb_id, 3'b000} +: 8];
          abort_d = 1'b0;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (i_complete) begin
          state_d = RELEASE;
          if (init_done_q) ack_d[grant_q] = 1'b1;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          abort_d = !init_done_q;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        // Hold off until the engine drops complete so it never sees a back-to-back start.
        if (!i_complete) begin
          if (init_done_q) begin
            state_d = IDLE;
          end else if (abort_q) begin
            state_d = INIT_SLEEP;
          end else begin
            case (step_q)
              2'd0:    state_d = INIT_PRESC;
              2'd1:    state_d = INIT_RUN;
              default: begin
                state_d     = IDLE;
                init_done_d = 1'b1;
              end
            endcase
          end
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= RESET_STATE;
      addr_q      <= '0;
      data_q      <= '0;
      grant_q     <= LAST_ID;
      step_q      <= '0;
      abort_q     <= 1'b0;
      init_done_q <= !INIT_EN;
      ack_q       <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      grant_q     <= grant_d;
      step_q      <= step_d;
      abort_q     <= abort_d;
      init_done_q <= init_done_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      start_q     <= (state_d == ISSUE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign o_ack       = ack_q;
  assign o_err       = err_q;
  assign o_grant_id  = grant_q;
  assign o_busy      = busy_q;
  assign o_init_done = init_done_q;
  assign o_start     = start_q;
  assign o_reg_addr  = addr_q;
  assign o_data      = data_q;

endmodule
`default_nettype wire

// File: tb/tb_servo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_servo_write_arbiter
// Directed, table-driven bench for servo_write_arbiter with a simple engine model.
// Rev    : 1.0
// ============================================================================
module tb_servo_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  i_req = '0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_data = '0;
  logic        i_complete = 1'b0;
  logic [3:0]  o_ack;
  logic        o_err;
  logic [1:0]  o_grant_id;
  logic        o_busy;
  logic        o_init_done;
  logic        o_start;
  logic [7:0]  o_reg_addr;
  logic [7:0]  o_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  servo_write_arbiter #(
    .N_REQ(4), .PRESCALE(8'h79), .INIT_EN(1'b1), .TIMEOUT_CYC(100)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req(i_req), .i_addr(i_addr), .i_data(i_data),
    .o_ack(o_ack), .o_err(o_err), .o_grant_id(o_grant_id), .o_busy(o_busy),
    .o_init_done(o_init_done), .o_start(o_start), .o_reg_addr(o_reg_addr),
    .o_data(o_data), .i_complete(i_complete)
  );

  // Engine model: raises complete ~10 cycles after start, drops it once start falls.
  int eng_cnt = 0;
  bit eng_en  = 1'b1;
  always @(negedge clk) begin
    if (!o_start) begin
      eng_cnt    = 0;
      i_complete = 1'b0;
    end else if (eng_en) begin
      if (eng_cnt >= 9) i_complete = 1'b1;
      else eng_cnt++;
    end
  end

  logic [15:0] frames[$];
  int          ack_cnt  = 0;
  int          err_cnt  = 0;
  int          start_hi = 0;
  logic        start_prev = 1'b0;
  always @(negedge clk) begin
    if (o_start && !start_prev) frames.push_back({o_reg_addr, o_data});
    start_prev = o_start;
    if (o_ack != 4'b0) ack_cnt++;
    if (o_err) err_cnt++;
    if (o_start) start_hi++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [15:0] frame_at(input int i);
    if (i < frames.size()) return frames[i];
    return 16'hDEAD;
  endfunction

  task automatic wait_ack(output logic [3:0] m);
    m = '0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (o_ack != 4'b0) begin
        m = o_ack;
        return;
      end
    end
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((o_busy || i_complete) && c < 60) begin
      step();
      c++;
    end
    chk("idle_reached", {31'd0, o_busy}, 32'd0);
  endtask

  task automatic wait_init(input string tag);
    int c = 0;
    while (!o_init_done && c < 300) begin
      step();
      c++;
    end
    chk({tag, "_init_done"}, {31'd0, o_init_done}, 32'd1);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  exp_id;
    logic [3:0]  exp_ack;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t        vecs[10];
  logic [3:0]  rr_exp[6];
  logic [3:0]  pair_exp[4];
  logic [3:0]  m;
  int          snap;
  localparam logic [31:0] ADDR_ALL = 32'h0F0D0706;
  localparam logic [31:0] DATA_ALL = 32'hFFD82211;

  initial begin
    // Pointer before row 0 is 1 (requester 1 served right after init).
    vecs[0] = '{4'b0100, ADDR_ALL, DATA_ALL,     2'd2, 4'b0100, 8'h0D, 8'hD8};
    vecs[1] = '{4'b0001, ADDR_ALL, DATA_ALL,     2'd0, 4'b0001, 8'h06, 8'h11};
    vecs[2] = '{4'b1000, ADDR_ALL, DATA_ALL,     2'd3, 4'b1000, 8'h0F, 8'hFF};
    vecs[3] = '{4'b0010, ADDR_ALL, 32'hFFD80011, 2'd1, 4'b0010, 8'h07, 8'h00};
    vecs[4] = '{4'b0110, ADDR_ALL, DATA_ALL,     2'd2, 4'b0100, 8'h0D, 8'hD8};
    vecs[5] = '{4'b0011, ADDR_ALL, DATA_ALL,     2'd0, 4'b0001, 8'h06, 8'h11};
    vecs[6] = '{4'b1001, ADDR_ALL, DATA_ALL,     2'd3, 4'b1000, 8'h0F, 8'hFF};
    vecs[7] = '{4'b1111, ADDR_ALL, DATA_ALL,     2'd0, 4'b0001, 8'h06, 8'h11};
    vecs[8] = '{4'b1010, ADDR_ALL, DATA_ALL,     2'd1, 4'b0010, 8'h07, 8'h22};
    vecs[9] = '{4'b1001, ADDR_ALL, DATA_ALL,     2'd3, 4'b1000, 8'h0F, 8'hFF};
    rr_exp   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    pair_exp = '{4'b1000, 4'b0001, 4'b1000, 4'b0001};

    #1 rst = 1'b1;
    step();
    step();
    chk("rst_start",     {31'd0, o_start},     32'd0);
    chk("rst_busy",      {31'd0, o_busy},      32'd0);
    chk("rst_init_done", {31'd0, o_init_done}, 32'd0);
    chk("rst_grant",     {30'd0, o_grant_id},  32'd3);
    chk("rst_addr_data", {16'd0, o_reg_addr, o_data}, 32'd0);
    chk("rst_ack_err",   {27'd0, o_ack, o_err}, 32'd0);

    // Init with requester 1 already requesting: it must wait for init to finish.
    i_addr = ADDR_ALL;
    i_data = DATA_ALL;
    i_req  = 4'b0010;
    rst    = 1'b0;
    wait_init("boot");
    chk("boot_frames_n", frames.size(), 32'd3);
    chk("boot_frame0", frame_at(0), 32'h0010);
    chk("boot_frame1", frame_at(1), 32'hFE79);
    chk("boot_frame2", frame_at(2), 32'h0000);
    chk("boot_no_ack", ack_cnt, 32'd0);
    chk("boot_idle_busy", {31'd0, o_busy}, 32'd0);
    step();
    chk("boot_req1_start", {31'd0, o_start}, 32'd1);
    chk("boot_req1_grant", {30'd0, o_grant_id}, 32'd1);
    wait_ack(m);
    i_req = '0;
    chk("boot_req1_ack", m, 32'b0010);
    chk("boot_req1_frame", frame_at(3), 32'h0722);

    for (int k = 0; k < 10; k++) begin
      wait_idle();
      i_addr = vecs[k].addr;
      i_data = vecs[k].data;
      i_req  = vecs[k].req;
      step();
      chk($sformatf("v%0d_start", k), {31'd0, o_start}, 32'd1);
      chk($sformatf("v%0d_frame", k), {o_reg_addr, o_data},
          {vecs[k].exp_addr, vecs[k].exp_data});
      chk($sformatf("v%0d_grant", k), o_grant_id, vecs[k].exp_id);
      wait_ack(m);
      i_req = '0;
      chk($sformatf("v%0d_ack", k), m, vecs[k].exp_ack);
      step();
      chk($sformatf("v%0d_ack_width", k), o_ack, 32'd0);
    end

    // All four held: full round-robin rotation starting from requester 0.
    wait_idle();
    i_addr = ADDR_ALL;
    i_data = DATA_ALL;
    i_req  = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      wait_ack(m);
      if (k == 5) i_req = '0;
      chk($sformatf("rr%0d_ack", k), m, rr_exp[k]);
    end

    // Only 0 and 3 persistent (pointer at 1): they must alternate.
    wait_idle();
    snap  = ack_cnt;
    i_req = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      wait_ack(m);
      if (k == 3) i_req = '0;
      chk($sformatf("pair%0d_ack", k), m, pair_exp[k]);
    end
    chk("pair_ack_count", ack_cnt - snap, 32'd4);

    // Timeout: requester 1 granted, engine silent; then requester 3 must be served.
    wait_idle();
    eng_en   = 1'b0;
    snap     = ack_cnt;
    err_cnt  = 0;
    start_hi = 0;
    i_req    = 4'b1010;
    begin
      int c = 0;
      while (!o_err && c < 300) begin
        step();
        c++;
      end
    end
    chk("to_err_seen", {31'd0, o_err}, 32'd1);
    chk("to_start_cycles", start_hi, 32'd100);
    chk("to_start_low", {31'd0, o_start}, 32'd0);
    chk("to_no_ack", ack_cnt - snap, 32'd0);
    eng_en = 1'b1;
    step();
    chk("to_err_width", {31'd0, o_err}, 32'd0);
    wait_ack(m);
    i_req = '0;
    chk("to_next_ack", m, 32'b1000);
    chk("to_err_count", err_cnt, 32'd1);

    // Reset while a granted frame is in flight.
    wait_idle();
    snap  = ack_cnt;
    i_req = 4'b0001;
    begin
      int c = 0;
      while (!o_start && c < 10) begin
        step();
        c++;
      end
    end
    chk("rs_start_up", {31'd0, o_start}, 32'd1);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rs_start_drop", {31'd0, o_start}, 32'd0);
    chk("rs_busy_drop", {31'd0, o_busy}, 32'd0);
    chk("rs_init_clear", {31'd0, o_init_done}, 32'd0);
    i_req = '0;
    step();
    rst = 1'b0;
    frames.delete();
    wait_init("rs");
    chk("rs_frame0", frame_at(0), 32'h0010);
    chk("rs_frame1", frame_at(1), 32'hFE79);
    chk("rs_frame2", frame_at(2), 32'h0000);
    step();
    step();
    chk("rs_no_ack", ack_cnt - snap, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
